adc_level_trigger: RTL and testbench
====================================

# adc_level_trigger

Self-triggering front end for the raw-ADC capture path. Watches one selected channel of the 8×16-bit adc_data bus in the adc_clk domain, applies a signed level/slope/hysteresis test with auto-timeout and holdoff, and emits a single-cycle trig pulse. trig is the adc_clk-domain start for the banyan capture, asserted in place of, or alongside, the host rawadc_trig.

## Interface
- dw, 16, sample width (signed two's complement)
- nch, 8, channels on adc_data
- cw, 16, width of the holdoff and auto-timeout counters
---
- adc_clk  in  1  sample clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- adc_data  in  nch*dw  channel k = adc_data[16k+15:16k]
- chan_sel  in  3  channel under test
- threshold  in  dw  signed trigger level
- hyst  in  dw-1  unsigned hysteresis
- slope  in  1  0 = rising, 1 = falling
- continuous  in  1  1 = re-arm automatically after holdoff
- arm  in  1  single-cycle; IDLE→PRIME
- disarm  in  1  single-cycle; any state→IDLE
- force  in  1  single-cycle software trigger while armed
- auto_timeout  in  cw  cycles armed before self-fire; 0 disables
- holdoff  in  cw  dead cycles after each trigger
- trig  out  1  single-cycle trigger pulse
- armed  out  1  state is PRIME or CROSS
- state  out  2  IDLE=0, PRIME=1, CROSS=2, HOLD=3
- trig_count  out  16  triggers since reset, wraps
- trig_sample  out  dw  stage-2 sample at the last fire

## Operation
- Stage 1 registers s1 = selected channel. Stage 2 registers s2 = s1 and the flags.
- Rising flags: primed = s1 ≤ threshold − hyst. crossed = s1 > threshold.
- Falling flags: primed = s1 ≥ threshold + hyst. crossed = s1 < threshold.
- All flag arithmetic is done in dw+2-bit signed math, so there is no wrap at the ±32768 extremes.
- IDLE: arm→PRIME. All other inputs are ignored.
- PRIME: primed→CROSS.
- CROSS: crossed→fire.
- In PRIME or CROSS, force or timeout → fire. Timeout means the armed counter equals auto_timeout, with auto_timeout ≠ 0.
- fire: trig=1, trig_count+1, trig_sample←s2, state→HOLD, hold counter cleared.
- HOLD: counts holdoff cycles. Exit after max(holdoff,1) cycles to PRIME if continuous, else IDLE.
- Priority, highest first: rst > disarm > fire > other transitions.
  - Simultaneous disarm+force: IDLE, no trig.
  - arm outside IDLE is ignored.
- The armed counter clears on entry to PRIME and counts through PRIME and CROSS without clearing on PRIME→CROSS. It saturates, so there is no wrap.
- Config inputs (chan_sel, threshold, hyst, slope) are quasi-static. A change takes effect at the next stage-1/2 edge and never alters state directly.

## Timing
- Reset: state IDLE. trig, armed, trig_count, trig_sample, s1, s2, flags and counters all 0.
- Crossing latency: a crossing sample present on adc_data at edge k gives trig high in the cycle after edge k+2, i.e. 3-edge latency.
- force latency: force sampled at edge k gives trig high after edge k. trig_sample then takes the s2 held at edge k.
- trig is never high for two consecutive cycles, because HOLD lasts at least 1 cycle.
- On entry to PRIME, flags already in the pipe are valid. A sample primed before arm counts only if it is still in s1 after arming.
- Reset asserted mid-HOLD or mid-CROSS forces IDLE immediately, asynchronously. The next trig requires a fresh arm.
- trig_count 0xFFFF + fire → 0x0000.

## Structure
- Package adc_trig_pkg holds:
  - state enum: IDLE/PRIME/CROSS/HOLD, 2-bit encoding as listed.
  - slope constants: SLOPE_RISE=0, SLOPE_FALL=1.
  - default dw/nch/cw.
- Sub-module trig_compare holds stage 1 and stage 2: channel mux, widened threshold±hyst arithmetic, primed/crossed registers, s2.
- The top level holds the FSM, counters and status outputs.

## Test plan
- Rising edge: threshold=1000, hyst=100, slope=0, ch3 ramps −500→2000 step 50, arm. Required response:
  - state goes PRIME→CROSS at ≤900.
  - One trig 3 edges after the first sample >1000.
  - trig_sample=1050, trig_count=1, then IDLE.
- Hysteresis reject: ch0 dithers 950↔1050 without ever reaching ≤900, after arm. Required: no trig for 10000 cycles.
- Falling continuous: slope=1, threshold=0, hyst=200, continuous=1, holdoff=50, ch7 square wave ±1000, period 200. Required:
  - trig on every falling edge.
  - Spacing = 200 cycles.
  - trig_count increments per edge.
- Auto timeout and extremes: auto_timeout=64, flat input −32768 with threshold=32767, hyst=32767. Required: no overflow miscompare, and trig exactly 64 cycles after arm.
- Priority: force and disarm asserted in the same cycle in CROSS. Required: state IDLE, no trig. Then force alone in PRIME gives trig next cycle.
- Reset mid-HOLD: assert rst during HOLD. Required: every output returns to 0 asynchronously. After release, a crossing without arm gives no trig.

Source files
------------

// File: rtl/adc_trig_pkg.sv
// Shared types and defaults for the ADC level trigger: state encoding,
// slope selection and the default bus/counter widths.
package adc_trig_pkg;

    localparam int DEF_DW  = 16;
    localparam int DEF_NCH = 8;
    localparam int DEF_CW  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CROSS = 2'd2,
        HOLD  = 2'd3
    } trig_state_e;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/trig_compare.sv
// Two-stage sample pipe: stage 1 picks the channel, stage 2 holds the sample
// together with its primed/crossed flags, evaluated in widened signed math.
module trig_compare
    import adc_trig_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int NCH = DEF_NCH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*DW-1:0]        adc_data,
    input  logic [$clog2(NCH)-1:0]   chan_sel,
    input  logic [DW-1:0]            threshold,
    input  logic [DW-2:0]            hyst,
    input  logic                     slope,
    output logic [DW-1:0]            s2,
    output logic                     primed,
    output logic                     crossed
);

    localparam int XW = DW + 2;

    logic [DW-1:0]        s1_q, s1_d;
    logic [DW-1:0]        s2_q, s2_d;
    logic                 primed_q, primed_d;
    logic                 crossed_q, crossed_d;
    logic signed [XW-1:0] s1_x, thr_x, hyst_x, lo_x, hi_x;

    // Channel mux and level arithmetic; two guard bits keep threshold+/-hyst exact.
    always_comb begin
        s1_d   = adc_data[chan_sel*DW +: DW];
        s2_d   = s1_q;
        s1_x   = $signed({{2{s1_q[DW-1]}}, s1_q});
        thr_x  = $signed({{2{threshold[DW-1]}}, threshold});
        hyst_x = $signed({3'b000, hyst});
        lo_x   = thr_x - hyst_x;
        hi_x   = thr_x + hyst_x;
        if (slope == SLOPE_FALL) begin
            primed_d  = (s1_x >= hi_x);
            crossed_d = (s1_x <  thr_x);
        end else begin
            primed_d  = (s1_x <= lo_x);
            crossed_d = (s1_x >  thr_x);
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= {DW{1'b0}};
            s2_q      <= {DW{1'b0}};
            primed_q  <= 1'b0;
            crossed_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            primed_q  <= primed_d;
            crossed_q <= crossed_d;
        end
    end

    assign s2      = s2_q;
    assign primed  = primed_q;
    assign crossed = crossed_q;

endmodule

// File: rtl/adc_level_trigger.sv
// Self-triggering ADC front end: arm/prime/cross state machine with force,
// auto-timeout and holdoff, producing a single-cycle registered trig pulse.
module adc_level_trigger
    import adc_trig_pkg::*;
#(
    parameter int dw  = DEF_DW,
    parameter int nch = DEF_NCH,
    parameter int cw  = DEF_CW
) (
    input  logic                   adc_clk,
    input  logic                   rst,
    input  logic [nch*dw-1:0]      adc_data,
    input  logic [$clog2(nch)-1:0] chan_sel,
    input  logic [dw-1:0]          threshold,
    input  logic [dw-2:0]          hyst,
    input  logic                   slope,
    input  logic                   continuous,
    input  logic                   arm,
    input  logic                   disarm,
    input  logic                   force_trig,
    input  logic [cw-1:0]          auto_timeout,
    input  logic [cw-1:0]          holdoff,
    output logic                   trig,
    output logic                   armed,
    output logic [1:0]             state,
    output logic [15:0]            trig_count,
    output logic [dw-1:0]          trig_sample
);

    localparam logic [cw-1:0] CNT_ONE  = {{(cw-1){1'b0}}, 1'b1};
    localparam logic [cw-1:0] CNT_ZERO = {cw{1'b0}};
    localparam logic [cw-1:0] CNT_MAX  = {cw{1'b1}};

    logic [dw-1:0] s2_s;
    logic          primed_s, crossed_s;

    trig_state_e   state_q, state_d;
    logic          trig_q, trig_d;
    logic          armed_q, armed_d;
    logic [15:0]   trig_count_q, trig_count_d;
    logic [dw-1:0] trig_sample_q, trig_sample_d;
    logic [cw-1:0] arm_cnt_q, arm_cnt_d;
    logic [cw-1:0] hold_cnt_q, hold_cnt_d;

    logic [cw-1:0] arm_cnt_inc_s, hold_inc_s, hold_len_s;
    logic          timeout_s, fire_s;

    trig_compare #(.DW(dw), .NCH(nch)) u_cmp (
        .clk       (adc_clk),
        .rst       (rst),
        .adc_data  (adc_data),
        .chan_sel  (chan_sel),
        .threshold (threshold),
        .hyst      (hyst),
        .slope     (slope),
        .s2        (s2_s),
        .primed    (primed_s),
        .crossed   (crossed_s)
    );

    // Saturating counter increments, timeout match and effective holdoff length.
    always_comb begin
        arm_cnt_inc_s = (arm_cnt_q == CNT_MAX) ? arm_cnt_q : arm_cnt_q + CNT_ONE;
        hold_inc_s    = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + CNT_ONE;
        hold_len_s    = (holdoff == CNT_ZERO) ? CNT_ONE : holdoff;
        timeout_s     = (auto_timeout != CNT_ZERO) && (arm_cnt_inc_s == auto_timeout);
    end

    // Next-state logic: disarm outranks fire, fire outranks ordinary transitions.
    always_comb begin
        state_d       = state_q;
        trig_d        = 1'b0;
        trig_count_d  = trig_count_q;
        trig_sample_d = trig_sample_q;
        arm_cnt_d     = arm_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        fire_s        = 1'b0;
        if (disarm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d   = PRIME;
                        arm_cnt_d = CNT_ZERO;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRIME: begin
                    if (force_trig || timeout_s) begin
                        fire_s = 1'b1;
                    end else begin
                        arm_cnt_d = arm_cnt_inc_s;
                        state_d   = primed_s ? CROSS : PRIME;
                    end
                end
                CROSS: begin
                    if (force_trig || timeout_s || crossed_s) begin
                        fire_s = 1'b1;
                    end else begin
                        arm_cnt_d = arm_cnt_inc_s;
                    end
                end
                HOLD: begin
                    hold_cnt_d = hold_inc_s;
                    if (hold_inc_s >= hold_len_s) begin
                        state_d   = continuous ? PRIME : IDLE;
                        arm_cnt_d = CNT_ZERO;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (fire_s) begin
                trig_d        = 1'b1;
                trig_count_d  = trig_count_q + 16'd1;
                trig_sample_d = s2_s;
                state_d       = HOLD;
                hold_cnt_d    = CNT_ZERO;
            end else begin
                trig_d = 1'b0;
            end
        end
        armed_d = (state_d == PRIME) || (state_d == CROSS);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            trig_q        <= 1'b0;
            armed_q       <= 1'b0;
            trig_count_q  <= 16'd0;
            trig_sample_q <= {dw{1'b0}};
            arm_cnt_q     <= CNT_ZERO;
            hold_cnt_q    <= CNT_ZERO;
        end else begin
            state_q       <= state_d;
            trig_q        <= trig_d;
            armed_q       <= armed_d;
            trig_count_q  <= trig_count_d;
            trig_sample_q <= trig_sample_d;
            arm_cnt_q     <= arm_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign trig        = trig_q;
    assign armed       = armed_q;
    assign state       = state_q;
    assign trig_count  = trig_count_q;
    assign trig_sample = trig_sample_q;

endmodule

// File: tb/tb_adc_level_trigger.sv
// Randomized and directed bench for adc_level_trigger against a behavioural
// model that tracks the sample pipe and trigger rules with plain integers.
module tb_adc_level_trigger;

    logic         adc_clk = 1'b0;
    logic         rst;
    logic [127:0] adc_data;
    logic [2:0]   chan_sel;
    logic [15:0]  threshold;
    logic [14:0]  hyst;
    logic         slope, continuous, arm, disarm, force_trig;
    logic [15:0]  auto_timeout, holdoff;
    logic         trig, armed;
    logic [1:0]   state;
    logic [15:0]  trig_count;
    logic [15:0]  trig_sample;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;
    int first_trig_edge;
    int trig_edges[$];

    // model state
    int m_state, m_armcnt, m_holdcnt, m_count, m_sample, m_trig;
    int m_s1, m_s2, m_pr, m_cr;

    adc_level_trigger dut (
        .adc_clk      (adc_clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .chan_sel     (chan_sel),
        .threshold    (threshold),
        .hyst         (hyst),
        .slope        (slope),
        .continuous   (continuous),
        .arm          (arm),
        .disarm       (disarm),
        .force_trig   (force_trig),
        .auto_timeout (auto_timeout),
        .holdoff      (holdoff),
        .trig         (trig),
        .armed        (armed),
        .state        (state),
        .trig_count   (trig_count),
        .trig_sample  (trig_sample)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_armcnt = 0; m_holdcnt = 0; m_count = 0;
        m_sample = 0; m_trig = 0; m_s1 = 0; m_s2 = 0; m_pr = 0; m_cr = 0;
    endfunction

    // Apply the trigger rules for one rising edge using the inputs present now.
    function automatic void model_edge();
        int th, hy, armed_cycles, hold_len, fire, tmo;
        th   = $signed(threshold);
        hy   = int'(hyst);
        fire = 0;
        m_trig = 0;
        if (disarm) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (arm) begin m_state = 1; m_armcnt = 0; end
        end else if (m_state == 1 || m_state == 2) begin
            armed_cycles = (m_armcnt + 1 > 65535) ? 65535 : m_armcnt + 1;
            tmo = (auto_timeout != 0) && (armed_cycles == int'(auto_timeout));
            if (force_trig || tmo || (m_state == 2 && m_cr)) fire = 1;
            else begin
                m_armcnt = armed_cycles;
                if (m_state == 1 && m_pr) m_state = 2;
            end
        end else begin
            hold_len  = (holdoff == 0) ? 1 : int'(holdoff);
            m_holdcnt = m_holdcnt + 1;
            if (m_holdcnt >= hold_len) begin
                m_state  = continuous ? 1 : 0;
                m_armcnt = 0;
            end
        end
        if (fire) begin
            m_trig    = 1;
            m_count   = (m_count + 1) % 65536;
            m_sample  = m_s2 & 32'hFFFF;
            m_state   = 3;
            m_holdcnt = 0;
        end
        m_pr = slope ? (m_s1 >= th + hy) : (m_s1 <= th - hy);
        m_cr = slope ? (m_s1 <  th)      : (m_s1 >  th);
        m_s2 = m_s1;
        m_s1 = $signed(adc_data[16*chan_sel +: 16]);
    endfunction

    task automatic compare_all();
        check("trig",        {31'd0, trig},  m_trig);
        check("state",       {30'd0, state}, m_state);
        check("armed",       {31'd0, armed}, (m_state == 1 || m_state == 2) ? 1 : 0);
        check("trig_count",  {16'd0, trig_count},  m_count);
        check("trig_sample", {16'd0, trig_sample}, m_sample);
    endtask

    task automatic cyc();
        @(posedge adc_clk);
        cyc_n++;
        model_edge();
        #1;
        compare_all();
        if (trig) begin
            trig_edges.push_back(cyc_n);
            if (first_trig_edge < 0) first_trig_edge = cyc_n;
        end
    endtask

    task automatic set_ch(input int k, input int v);
        adc_data[16*k +: 16] = v[15:0];
    endtask

    task automatic noise();
        adc_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic pulse_arm();
        arm = 1'b1; cyc(); arm = 1'b0;
    endtask

    task automatic clear_log();
        first_trig_edge = -1;
        trig_edges.delete();
    endtask

    initial begin
        int cross_edge, arm_edge, cnt0, v, k;
        rst = 1'b1; adc_data = '0; chan_sel = 3'd0; threshold = 16'd0; hyst = 15'd0;
        slope = 1'b0; continuous = 1'b0; arm = 1'b0; disarm = 1'b0; force_trig = 1'b0;
        auto_timeout = 16'd0; holdoff = 16'd0;
        model_reset();
        clear_log();
        #12;
        check("rst_state", {30'd0, state}, 0);
        check("rst_trig",  {31'd0, trig}, 0);
        check("rst_count", {16'd0, trig_count}, 0);
        rst = 1'b0;

        // rising edge ramp on ch3
        chan_sel = 3'd3; threshold = 16'd1000; hyst = 15'd100; holdoff = 16'd4;
        noise(); set_ch(3, -500);
        for (int i = 0; i < 3; i++) cyc();
        pulse_arm();
        clear_log();
        cross_edge = -1;
        for (v = -500; v <= 2000; v += 50) begin
            noise(); set_ch(3, v);
            cyc();
            if (v > 1000 && cross_edge < 0) cross_edge = cyc_n;
        end
        for (int i = 0; i < 10; i++) cyc();
        check("t1_latency", first_trig_edge - cross_edge, 2);
        check("t1_ntrig",   trig_edges.size(), 1);
        check("t1_sample",  {16'd0, trig_sample}, 1050);
        check("t1_count",   {16'd0, trig_count}, 1);
        check("t1_idle",    {30'd0, state}, 0);

        // hysteresis reject on ch0
        chan_sel = 3'd0;
        noise(); set_ch(0, 1050);
        for (int i = 0; i < 4; i++) cyc();
        pulse_arm();
        cnt0 = trig_count;
        for (int i = 0; i < 10000; i++) begin
            set_ch(0, (i % 2) ? 950 : 1050);
            cyc();
        end
        check("t2_notrig", {16'd0, trig_count}, cnt0);
        check("t2_prime",  {30'd0, state}, 1);
        disarm = 1'b1; cyc(); disarm = 1'b0;

        // falling continuous square wave on ch7
        chan_sel = 3'd7; slope = 1'b1; threshold = 16'd0; hyst = 15'd200;
        continuous = 1'b1; holdoff = 16'd50;
        noise(); set_ch(7, 1000);
        for (int i = 0; i < 5; i++) cyc();
        pulse_arm();
        clear_log();
        cnt0 = trig_count;
        for (int i = 0; i < 1000; i++) begin
            set_ch(7, ((i % 200) < 100) ? 1000 : -1000);
            cyc();
        end
        check("t3_ntrig", trig_edges.size(), 5);
        for (int i = 1; i < trig_edges.size(); i++)
            check("t3_spacing", trig_edges[i] - trig_edges[i-1], 200);
        check("t3_count", {16'd0, trig_count} - cnt0, 5);
        disarm = 1'b1; cyc(); disarm = 1'b0;
        continuous = 1'b0;

        // auto timeout at the numeric extremes
        chan_sel = 3'd2; slope = 1'b0; threshold = 16'd32767; hyst = 15'd32767;
        auto_timeout = 16'd64; holdoff = 16'd1;
        noise(); set_ch(2, -32768);
        for (int i = 0; i < 4; i++) cyc();
        clear_log();
        pulse_arm();
        arm_edge = cyc_n;
        for (int i = 0; i < 100 && first_trig_edge < 0; i++) cyc();
        check("t4_timeout", first_trig_edge - arm_edge, 64);
        check("t4_sample", {16'd0, trig_sample}, 32768);
        for (int i = 0; i < 4; i++) cyc();
        auto_timeout = 16'd0;

        // disarm beats force in CROSS; force alone fires from PRIME
        chan_sel = 3'd1; threshold = 16'd1000; hyst = 15'd100; holdoff = 16'd2;
        noise(); set_ch(1, 0);
        for (int i = 0; i < 4; i++) cyc();
        pulse_arm();
        for (int i = 0; i < 10 && state != 2'd2; i++) cyc();
        check("t5_cross", {30'd0, state}, 2);
        cnt0 = trig_count;
        force_trig = 1'b1; disarm = 1'b1; cyc(); force_trig = 1'b0; disarm = 1'b0;
        check("t5_pri_state", {30'd0, state}, 0);
        check("t5_pri_trig",  {31'd0, trig}, 0);
        set_ch(1, 2000);
        for (int i = 0; i < 3; i++) cyc();
        pulse_arm();
        cyc();
        check("t5_prime", {30'd0, state}, 1);
        force_trig = 1'b1; cyc(); force_trig = 1'b0;
        check("t5_force", {31'd0, trig}, 1);
        check("t5_count", {16'd0, trig_count}, cnt0 + 1);

        // asynchronous reset in the middle of HOLD
        holdoff = 16'd1000;
        for (int i = 0; i < 5; i++) cyc();
        pulse_arm();
        force_trig = 1'b1; cyc(); force_trig = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        check("t6_hold", {30'd0, state}, 3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_state",  {30'd0, state}, 0);
        check("t6_armed",  {31'd0, armed}, 0);
        check("t6_trig",   {31'd0, trig}, 0);
        check("t6_count",  {16'd0, trig_count}, 0);
        check("t6_sample", {16'd0, trig_sample}, 0);
        @(negedge adc_clk);
        @(negedge adc_clk);
        rst = 1'b0;
        for (v = 0; v <= 2000; v += 100) begin
            set_ch(1, v);
            cyc();
        end
        check("t6_noarm", {16'd0, trig_count}, 0);

        // randomized configuration and control traffic
        for (int i = 0; i < 3000; i++) begin
            if ((i % 150) == 0) begin
                chan_sel     = 3'($urandom_range(0, 7));
                threshold    = 16'(int'($urandom_range(0, 4000)) - 2000);
                hyst         = 15'($urandom_range(0, 500));
                slope        = 1'($urandom_range(0, 1));
                continuous   = 1'($urandom_range(0, 1));
                auto_timeout = 16'($urandom_range(0, 100));
                holdoff      = 16'($urandom_range(0, 20));
            end
            noise();
            k = int'(chan_sel);
            if ($urandom_range(0, 15) == 0) set_ch(k, ($urandom_range(0, 1) != 0) ? 32767 : -32768);
            else set_ch(k, int'($urandom_range(0, 6000)) - 3000);
            arm        = ($urandom_range(0, 7) == 0);
            disarm     = ($urandom_range(0, 63) == 0);
            force_trig = ($urandom_range(0, 31) == 0);
            cyc();
        end
        arm = 1'b0; disarm = 1'b0; force_trig = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
